// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
//   - OP_* : 3-bit ALU operation codes (110/111 are unused and yield 0)
//   - state_t : sequencer FSM states, one per cycle of an operation
//   - DEF_W : default datapath width
package alu_pkg;

    localparam int DEF_W = 32;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational W-bit ALU.
//   a, b : operands
//   op   : operation code (see alu_pkg OP_*)
//   y    : result, modulo 2^W; unused codes give 0
module alu_core
    import alu_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_MOV:  y = a;
            OP_NOT:  y = ~a;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller: accepts one register-to-register op, reads two
// operands from an internal register file, runs the ALU, writes back.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : op handshake (ready only in IDLE)
//   req_op/src1/src2/dst  : op code and register indices, captured at accept
//   ld_en/ld_addr/ld_data : direct register load, honoured only in IDLE
//   done                  : high for the single WRITE cycle
//   result, zero          : registered ALU result and its zero flag
//   busy                  : ~req_ready
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int NREG = 8,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_src1,
    input  logic [AW-1:0] req_src2,
    input  logic [AW-1:0] req_dst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          zero,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [2:0]    op_q;
    logic [AW-1:0] src1_q, src2_q, dst_q;
    logic [W-1:0]  a_q, b_q;
    logic [W-1:0]  alu_y;
    logic [W-1:0]  rf [NREG];

    logic accept;
    assign accept = (state_q == ST_IDLE) && req_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and Moore outputs
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_READ;
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy = ~req_ready;

    alu_core #(.W(W)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    // Datapath: request capture, operand latch, result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= req_op;
                src1_q <= req_src1;
                src2_q <= req_src2;
                dst_q  <= req_dst;
            end
            // Operands are read at the end of READ, so a load issued in the
            // accept cycle (or a write-back from the previous op) is visible.
            if (state_q == ST_READ) begin
                a_q <= rf[src1_q];
                b_q <= rf[src2_q];
            end
            if (state_q == ST_EXEC) begin
                result <= alu_y;
                zero   <= (alu_y == '0);
            end
        end
    end

    // Register file: host load in IDLE, write-back at the close of WRITE.
    // The two never coincide since they live in different states.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if ((state_q == ST_IDLE) && ld_en) begin
            rf[ld_addr] <= ld_data;
        end else if (state_q == ST_WRITE) begin
            rf[dst_q] <= result;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [2:0]  req_src1, req_src2, req_dst;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.W(32), .NREG(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .req_dst   (req_dst),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    typedef struct {
        bit          do_ld;
        logic [2:0]  la;
        logic [31:0] ld;
        logic [2:0]  op;
        logic [2:0]  s1, s2, d;
        logic [31:0] exp_res;
        logic        exp_z;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one op from IDLE and check the fixed 4-cycle timeline.
    task automatic do_op(input string name, input logic [2:0] op, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] d,
                         input logic [31:0] er, input logic ez);
        @(negedge clk);
        chk({name, " ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2; req_dst = d;
        @(negedge clk);                                   // READ
        req_valid = 1'b0; req_op = 3'b111; req_src1 = 3'd7; req_src2 = 3'd7; req_dst = 3'd7;
        chk({name, " busy"}, {31'b0, busy}, 32'd1);
        chk({name, " done@read"}, {31'b0, done}, 32'd0);
        @(negedge clk);                                   // EXEC
        chk({name, " done@exec"}, {31'b0, done}, 32'd0);
        @(negedge clk);                                   // WRITE
        chk({name, " done"}, {31'b0, done}, 32'd1);
        chk({name, " result"}, result, er);
        chk({name, " zero"}, {31'b0, zero}, {31'b0, ez});
        @(negedge clk);                                   // back in IDLE
        chk({name, " done pulse"}, {31'b0, done}, 32'd0);
        chk({name, " result hold"}, result, er);
    endtask

    initial begin
        int          didx [2];
        logic [31:0] dres [2];
        int          ndone;

        vecs[0]  = '{0, 0, 0,            OP_ADD, 1, 2, 3, 32'd8,         0};
        vecs[1]  = '{0, 0, 0,            OP_MOV, 3, 0, 7, 32'd8,         0};
        vecs[2]  = '{0, 0, 0,            OP_SUB, 2, 1, 4, 32'hFFFF_FFFE, 0};
        vecs[3]  = '{1, 5, 32'hFFFF_FFFF, OP_ADD, 5, 5, 5, 32'hFFFF_FFFE, 0};
        vecs[4]  = '{0, 0, 0,            OP_NOT, 0, 0, 7, 32'hFFFF_FFFF, 0};
        vecs[5]  = '{0, 0, 0,            OP_AND, 1, 0, 7, 32'd0,         1};
        vecs[6]  = '{0, 0, 0,            3'b110, 1, 2, 7, 32'd0,         1};
        vecs[7]  = '{0, 0, 0,            3'b111, 5, 5, 7, 32'd0,         1};
        vecs[8]  = '{0, 0, 0,            OP_OR,  1, 2, 7, 32'd7,         0};
        vecs[9]  = '{0, 0, 0,            OP_MOV, 4, 0, 0, 32'hFFFF_FFFE, 0};
        vecs[10] = '{0, 0, 0,            OP_MOV, 0, 0, 7, 32'hFFFF_FFFE, 0};
        vecs[11] = '{0, 0, 0,            OP_AND, 0, 1, 7, 32'd4,         0};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
        req_dst = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset ready",  {31'b0, req_ready}, 32'd1);
        chk("reset busy",   {31'b0, busy},      32'd0);
        chk("reset done",   {31'b0, done},      32'd0);
        chk("reset result", result,             32'd0);
        chk("reset zero",   {31'b0, zero},      32'd0);

        for (int r = 0; r < 8; r++)
            do_op($sformatf("rd r%0d", r), OP_MOV, 3'(r), 3'(r), 3'(r), 32'd0, 1'b1);

        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        foreach (vecs[i]) begin
            if (vecs[i].do_ld) load(vecs[i].la, vecs[i].ld);
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].d,
                  vecs[i].exp_res, vecs[i].exp_z);
        end

        // Load and accept in the same IDLE cycle: READ sees the new value.
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'd100;
        req_valid = 1'b1; req_op = OP_MOV; req_src1 = 3'd2; req_src2 = 3'd2; req_dst = 3'd6;
        @(negedge clk);
        ld_en = 1'b0; req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("ld+acc done",   {31'b0, done}, 32'd1);
        chk("ld+acc result", result,        32'd100);

        // Load during busy is ignored.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MOV; req_src1 = 3'd3; req_src2 = 3'd3; req_dst = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        do_op("ld busy", OP_MOV, 3'd3, 3'd3, 3'd7, 32'd8, 1'b0);

        // Back-to-back with req_valid held: r1 = r1 + r1 twice.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_ADD; req_src1 = 3'd1; req_src2 = 3'd1; req_dst = 3'd1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) chk("b2b ready gap", {31'b0, req_ready}, 32'd1);
            if (i == 1) chk("b2b ignored", {31'b0, req_ready}, 32'd0);
            if (done) begin
                if (ndone < 2) begin didx[ndone] = i; dres[ndone] = result; end
                ndone++;
            end
            if (i == 6) req_valid = 1'b0;
        end
        chk("b2b count", 32'(ndone), 32'd2);
        if (ndone >= 2) begin
            chk("b2b first at",  32'(didx[0]), 32'd2);
            chk("b2b second at", 32'(didx[1]), 32'd6);
            chk("b2b first",     dres[0],      32'd10);
            chk("b2b second",    dres[1],      32'd20);
        end

        // Reset during EXEC: no done, write discarded.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_ADD; req_src1 = 3'd1; req_src2 = 3'd2; req_dst = 3'd6;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst mid ready",  {31'b0, req_ready}, 32'd1);
        chk("rst mid done",   {31'b0, done},      32'd0);
        chk("rst mid result", result,             32'd0);
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst mid no done", 32'(ndone), 32'd0);
        do_op("rst r6", OP_MOV, 3'd6, 3'd6, 3'd0, 32'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
